flag_period_monitor: RTL
========================

Name: flag_period_monitor

Overview:
- Receiving end of the periodic counter flag.
- Takes the single-bit `dout` flag produced by the free-running counter and measures the interval between its rising edges in `sys_clk` cycles.
- Checks each interval against an expected period with tolerance, declares lock after consecutive good intervals, and flags missing pulses (timeout).
- Sits beside the counter in the same 50 MHz domain, as a self-check / health monitor.

Parameters:
- CNT_W, 32, width of the interval counter and `period` output.
- EXP_PERIOD, 50_000_000, expected rising-edge interval in `sys_clk` cycles.
- TOL, 2, allowed absolute deviation from EXP_PERIOD in cycles; inclusive.
- LOCK_N, 4, consecutive good intervals required to assert `locked` (>=1).
- TIMEOUT, 100_000_000, longest accepted interval; must be < 2^CNT_W.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- din  in  1  flag under test, synchronous to sys_clk
- err_clr  in  1  synchronous clear of err_cnt
- period  out  CNT_W  last measured interval, held until next measurement
- period_vld  out  1  one-cycle strobe: new `period` value
- locked  out  1  LOCK_N consecutive in-tolerance intervals seen, none bad since
- err_cnt  out  16  count of out-of-tolerance intervals, saturates at 16'hFFFF
- timeout  out  1  one-cycle strobe: no rising edge within TIMEOUT cycles

Behaviour:
- Reset (async assert, sync release): state IDLE; period=0, period_vld=0, locked=0, err_cnt=0, timeout=0; interval counter and good counter = 0; din history register = 0.
- Edge detect: din registered once; rise = din & ~din_q. Level-high or level-low din produces no events.
- Interval definition: rises sampled at edges k and k+P give a measured period of P.
- Latency: for a rise sampled at edge k, period/period_vld update at edge k+1. period_vld is high for exactly one cycle.
- Interval counter: restarts on every rise; saturates, never wraps.
- Good interval: EXP_PERIOD-TOL <= P <= EXP_PERIOD+TOL. Use unsigned compare with no underflow; if TOL > EXP_PERIOD, the lower bound is 0.
- IDLE state:
  - Waits for first rise; no period_vld is issued.
  - Rise -> MEAS; interval counter starts.
- MEAS state, on rise:
  - period_vld=1, period=P.
  - Good interval: good_cnt++. When good_cnt reaches LOCK_N -> LOCKED, locked=1 at the same edge as that period_vld.
  - Bad interval: good_cnt=0, err_cnt++.
- LOCKED state, on rise:
  - Good interval: stay LOCKED.
  - Bad interval: -> MEAS, locked=0, good_cnt=0, err_cnt++. All of these take effect at the same edge as period_vld.
- Timeout:
  - In MEAS or LOCKED, fires if TIMEOUT+1 cycles elapse since the last rise with no new rise.
  - Effect: timeout=1 for one cycle, locked=0, good_cnt=0, -> IDLE.
  - Timeout does not increment err_cnt.
- Simultaneous timeout and rise at the same edge: timeout wins. The rise is treated as the arming edge from IDLE (-> MEAS, no period_vld).
- err_clr:
  - Synchronous; clears err_cnt at next edge.
  - Wins over a same-cycle increment (result 0).
  - Does not affect state, locked or period.
- Reset mid-operation: all outputs drop immediately (async). After release, the first rise only arms; no stale period is reported.

Test Plan:
Bench overrides CNT_W=8, EXP_PERIOD=10, TOL=1, LOCK_N=3, TIMEOUT=25.
1. Reset, then 4 rises spaced 10 cycles -> no strobe on first rise; three period_vld with period=10; locked rises with the 3rd strobe; err_cnt=0, timeout never asserted.
2. From LOCKED, intervals 13, 9, 11, 10 -> strobe period=13 with locked=0 and err_cnt=1; locked reasserts with the strobe for interval 10; err_cnt stays 1.
3. Tolerance boundaries, intervals 9, 11, 8, 12 -> first two good (good_cnt 1, 2); 8 and 12 each increment err_cnt (total 2); locked stays 0.
4. Stop pulses after lock -> timeout pulse exactly 26 cycles after last rise; locked=0, no period_vld. Next rise produces no strobe; the following rise at +10 gives period=10.
5. din held high 40 cycles after the arming rise -> single rise only; timeout at +26; no period_vld.
6. Assert sys_rst_n=0 mid-lock -> all outputs 0 without a clock edge. Then, after re-lock, drive err_clr together with a bad interval (period=15) -> err_cnt=0 at next edge, period_vld with period=15, locked=0.

Source files
------------

// File: rtl/flag_period_monitor.sv
// Health monitor for a periodic single-bit flag: measures rise-to-rise interval,
// checks it against an expected period, tracks lock, counts bad intervals and missing pulses.
module flag_period_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned EXP_PERIOD = 50_000_000,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned TIMEOUT    = 100_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             din,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic [15:0]      err_cnt,
    output logic             timeout
);

    // state  | meaning
    // IDLE   | waiting for an arming rise, nothing measured yet
    // MEAS   | measuring, fewer than LOCK_N consecutive good intervals
    // LOCKED | LOCK_N good intervals seen, no bad one since
    typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_t;

    localparam int unsigned GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N);
    localparam logic [GW-1:0] LOCK_M1 = GW'(LOCK_N - 1);

    // Bounds are compared one bit wider than the counter so EXP_PERIOD+TOL and
    // TIMEOUT+1 never wrap.
    localparam int unsigned   XW     = CNT_W + 1;
    localparam logic [XW-1:0] LO_B   = (TOL > EXP_PERIOD) ? '0 : XW'(EXP_PERIOD - TOL);
    localparam logic [XW-1:0] HI_B   = XW'(EXP_PERIOD) + XW'(TOL);
    localparam logic [XW-1:0] TO_LIM = XW'(TIMEOUT) + XW'(1);

    state_t           state;
    logic             din_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    logic [XW-1:0]    cnt_x;
    logic             in_tol;
    logic             to_hit;
    logic             bad_hit;

    assign cnt_x   = {1'b0, cnt};
    assign in_tol  = (cnt_x >= LO_B) && (cnt_x <= HI_B);
    assign to_hit  = (state != IDLE) && (cnt_x >= TO_LIM);
    assign bad_hit = (state != IDLE) && rise_q && !to_hit && !in_tol;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            din_q      <= 1'b0;
            rise_q     <= 1'b0;
            cnt        <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
            timeout    <= 1'b0;
        end else begin
            din_q      <= din;
            rise_q     <= din & ~din_q;
            period_vld <= 1'b0;
            timeout    <= 1'b0;

            // cnt holds the interval length at the edge the next rise is processed
            if (rise_q)
                cnt <= CNT_W'(1);
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);

            if (err_clr)
                err_cnt <= '0;
            else if (bad_hit && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (rise_q)
                        state <= MEAS;
                end
                MEAS: begin
                    if (to_hit) begin
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        state    <= rise_q ? MEAS : IDLE;
                    end else if (rise_q) begin
                        period_vld <= 1'b1;
                        period     <= cnt;
                        if (!in_tol) begin
                            good_cnt <= '0;
                        end else if (good_cnt == LOCK_M1) begin
                            good_cnt <= '0;
                            locked   <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (to_hit) begin
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        state    <= rise_q ? MEAS : IDLE;
                    end else if (rise_q) begin
                        period_vld <= 1'b1;
                        period     <= cnt;
                        if (!in_tol) begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= MEAS;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
